// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the datapath, stage controls back to it.
// master = the hazard controller, slave = the datapath side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) ();
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_regdest;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_regwrite, ex_regdest,
           ex_branch_taken, mem_req, mem_ready, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           memwb_bubble, halted, mem_timeout, stall_cycles
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_regwrite, ex_regdest,
           ex_branch_taken, mem_req, mem_ready, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           memwb_bubble, halted, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline registers: load-use stalls, branch flushes,
// data-memory wait states and a precise halt/drain sequence.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned DRAIN_CYC = 4
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_hazard_ctrl_if.master bus
);
  localparam int unsigned WaitW  = $clog2(MAX_WAIT + 1);
  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [WaitW-1:0]  WaitMax   = WaitW'(MAX_WAIT);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} ctrlState_e;

  ctrlState_e        stateQ, stateD, retQ, retD, evalState;
  logic [WaitW-1:0]  waitCntQ, waitCntD;
  logic [DrainW-1:0] drainCntQ, drainCntD;
  logic              timeoutQ, timeoutD;
  logic [CNT_W-1:0]  stallCntQ, stallCntD;

  logic [REG_W-1:0]  exDest;
  logic              luHaz, mStall, freeze;
  logic              pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic              ifidFlush, idexBubble, memwbBubble, haltedOut;

  assign exDest = bus.ex_regdest;
  assign luHaz  = bus.ex_memread & bus.ex_regwrite & (exDest != '0) &
                  ((exDest == bus.id_rs) | (bus.id_uses_rt & (exDest == bus.id_rt)));
  assign mStall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    pcEn        = 1'b1;
    ifidEn      = 1'b1;
    idexEn      = 1'b1;
    exmemEn     = 1'b1;
    memwbEn     = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    memwbBubble = 1'b0;
    haltedOut   = 1'b0;
    freeze      = 1'b0;
    retD        = retQ;
    waitCntD    = waitCntQ;
    drainCntD   = drainCntQ;
    timeoutD    = timeoutQ;
    stallCntD   = stallCntQ;

    // A wait that completes this cycle applies the interrupted state's rules immediately.
    evalState = ((stateQ == StMemWait) && bus.mem_ready) ? retQ : stateQ;
    stateD    = evalState;

    unique case (evalState)
      StRun: begin
        if (mStall) begin
          freeze   = 1'b1;
          stateD   = StMemWait;
          retD     = StRun;
          waitCntD = WaitW'(1);
        end else if (bus.ex_branch_taken) begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
        end else if (luHaz) begin
          pcEn       = 1'b0;
          ifidEn     = 1'b0;
          idexBubble = 1'b1;
        end else if (bus.halt_req) begin
          pcEn      = 1'b0;
          ifidFlush = 1'b1;
          stateD    = StDrain;
          drainCntD = '0;
        end
      end
      StMemWait: begin
        freeze = 1'b1;
        if (waitCntQ != WaitMax) waitCntD = waitCntQ + WaitW'(1);
      end
      StDrain: begin
        if (mStall) begin
          freeze   = 1'b1;
          stateD   = StMemWait;
          retD     = StDrain;
          waitCntD = WaitW'(1);
        end else begin
          // A branch resolving mid-drain still loads its target so resume is precise.
          pcEn      = bus.ex_branch_taken;
          ifidFlush = 1'b1;
          if (drainCntQ == DrainLast) stateD = StHalted;
          else drainCntD = drainCntQ + DrainW'(1);
        end
      end
      StHalted: begin
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexEn    = 1'b0;
        exmemEn   = 1'b0;
        memwbEn   = 1'b0;
        haltedOut = 1'b1;
        if (!bus.halt_req) stateD = StRun;
      end
    endcase

    // Memory stall: hold everything upstream, let MEM/WB retire a bubble.
    if (freeze) begin
      pcEn        = 1'b0;
      ifidEn      = 1'b0;
      idexEn      = 1'b0;
      exmemEn     = 1'b0;
      memwbEn     = 1'b1;
      memwbBubble = 1'b1;
    end

    if (waitCntD == WaitMax) timeoutD = 1'b1;

    if (!pcEn && (stateQ != StHalted) && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + CNT_W'(1);
    end

    if (reset) begin
      pcEn        = 1'b0;
      ifidEn      = 1'b0;
      idexEn      = 1'b0;
      exmemEn     = 1'b0;
      memwbEn     = 1'b0;
      ifidFlush   = 1'b0;
      idexBubble  = 1'b0;
      memwbBubble = 1'b0;
      haltedOut   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StRun;
      retQ      <= StRun;
      waitCntQ  <= '0;
      drainCntQ <= '0;
      timeoutQ  <= 1'b0;
      stallCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      retQ      <= retD;
      waitCntQ  <= waitCntD;
      drainCntQ <= drainCntD;
      timeoutQ  <= timeoutD;
      stallCntQ <= stallCntD;
    end
  end

  assign bus.pc_en        = pcEn;
  assign bus.ifid_en      = ifidEn;
  assign bus.idex_en      = idexEn;
  assign bus.exmem_en     = exmemEn;
  assign bus.memwb_en     = memwbEn;
  assign bus.ifid_flush   = ifidFlush;
  assign bus.idex_bubble  = idexBubble;
  assign bus.memwb_bubble = memwbBubble;
  assign bus.halted       = haltedOut;
  assign bus.mem_timeout  = timeoutQ;
  assign bus.stall_cycles = stallCntQ;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural
// model of the hazard/stall/halt rules.
module tb_pipeline_hazard_ctrl;
  localparam int MaxWait  = 15;
  localparam int DrainCyc = 4;
  localparam int CntMax   = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W(5),
    .CNT_W(16),
    .MAX_WAIT(MaxWait),
    .DRAIN_CYC(DrainCyc)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: mode names rather than an encoding.
  string mState = "RUN";
  string mRet   = "RUN";
  int    mWait  = 0;
  int    mDrain = 0;
  int    mStall = 0;
  bit    mTimeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_regdest = '0;
    bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
  task automatic stepCycle();
    bit lu, ms, frz, fl, bb, mb, hl;
    logic [4:0] en;  // {pc, ifid, idex, exmem, memwb}
    string act, nxt;
    #3;
    check("mem_timeout", 32'(bus.mem_timeout), 32'(mTimeout));
    check("stall_cycles", 32'(bus.stall_cycles), 32'(mStall));

    lu = bus.ex_memread && bus.ex_regwrite && (bus.ex_regdest != 0) &&
         ((bus.ex_regdest == bus.id_rs) || (bus.id_uses_rt && (bus.ex_regdest == bus.id_rt)));
    ms = bus.mem_req && !bus.mem_ready;
    en = 5'b11111; fl = 0; bb = 0; mb = 0; hl = 0; frz = 0; nxt = mState;

    if (reset) begin
      en = 5'b00000;
    end else begin
      act = (mState == "WAIT" && bus.mem_ready) ? mRet : mState;
      nxt = act;
      if (act == "WAIT") begin
        frz = 1;
        if (mWait < MaxWait) mWait++;
      end else if (act == "HALT") begin
        en = 5'b00000; hl = 1;
        if (!bus.halt_req) nxt = "RUN";
      end else if (ms) begin
        frz = 1; mRet = act; mWait = 1; nxt = "WAIT";
      end else if (act == "DRAIN") begin
        en[4] = bus.ex_branch_taken; fl = 1;
        if (mDrain == DrainCyc - 1) nxt = "HALT";
        else mDrain++;
      end else if (bus.ex_branch_taken) begin
        fl = 1; bb = 1;
      end else if (lu) begin
        en[4] = 0; en[3] = 0; bb = 1;
      end else if (bus.halt_req) begin
        en[4] = 0; fl = 1; nxt = "DRAIN"; mDrain = 0;
      end
      if (frz) begin
        en = 5'b00001; mb = 1;
      end
      if (mWait >= MaxWait) mTimeout = 1;
    end

    check("ctrl", 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                       bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble, bus.halted}),
          32'({en, fl, bb, mb, hl}));

    if (reset) begin
      mState = "RUN"; mRet = "RUN"; mWait = 0; mDrain = 0; mStall = 0; mTimeout = 0;
    end else begin
      if (!en[4] && mState != "HALT" && mStall < CntMax) mStall++;
      mState = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset cycle, then a load-use hazard.
    stepCycle();
    reset = 1'b0;
    check("rst_stall", 32'(bus.stall_cycles), 32'd0);
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_regdest = 5'd2; bus.id_rs = 5'd2;
    bus.id_rt = 5'd4; bus.id_uses_rt = 1;
    stepCycle();
    check("t1_stall_cnt", 32'(bus.stall_cycles), 32'd1);
    idle();
    #3 check("t1_resume_pc", 32'(bus.pc_en), 32'd1);
    stepCycle();

    // Register 0 as load destination.
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_regdest = 5'd0; bus.id_rs = 5'd0;
    #3 check("t2_all_en", 32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                               bus.memwb_en}), 32'h1f);
    stepCycle();

    // Branch beats load-use.
    bus.ex_regdest = 5'd7; bus.id_rs = 5'd7; bus.ex_branch_taken = 1;
    #3 check("t3_branch", 32'({bus.ifid_flush, bus.idex_bubble, bus.pc_en}), 32'b111);
    stepCycle();

    // Short memory wait.
    idle();
    bus.mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #3 check("t4_freeze_bubble", 32'(bus.memwb_bubble), 32'd1);
      stepCycle();
    end
    bus.mem_ready = 1;
    #3 check("t4_resume_pc", 32'(bus.pc_en), 32'd1);
    stepCycle();
    check("t4_no_timeout", 32'(bus.mem_timeout), 32'd0);

    // Long wait: timeout after exactly MaxWait low cycles.
    bus.mem_ready = 0;
    repeat (MaxWait - 1) stepCycle();
    check("t4_timeout_early", 32'(bus.mem_timeout), 32'd0);
    stepCycle();
    check("t4_timeout_set", 32'(bus.mem_timeout), 32'd1);
    bus.mem_ready = 1;
    stepCycle();
    idle();
    repeat (3) stepCycle();
    check("t4_timeout_sticky", 32'(bus.mem_timeout), 32'd1);

    // Reset while waiting with timeout set.
    bus.mem_req = 1;
    repeat (2) stepCycle();
    reset = 1;
    stepCycle();
    reset = 0;
    idle();
    check("t6_timeout_clr", 32'(bus.mem_timeout), 32'd0);
    check("t6_stall_clr", 32'(bus.stall_cycles), 32'd0);
    #3 check("t6_run_pc", 32'(bus.pc_en), 32'd1);
    stepCycle();

    // Halt pulse: four drain cycles, then halted until the request is gone.
    bus.halt_req = 1;
    stepCycle();
    bus.halt_req = 0;
    repeat (DrainCyc) stepCycle();
    #3 check("t5_halted", 32'(bus.halted), 32'd1);
    stepCycle();
    #3 check("t5_resumed", 32'(bus.halted), 32'd0);
    stepCycle();

    // Halt with a memory stall in the middle of the drain.
    bus.halt_req = 1;
    stepCycle();
    bus.halt_req = 0;
    repeat (2) stepCycle();
    bus.mem_req = 1; bus.mem_ready = 0;
    repeat (2) stepCycle();
    bus.mem_ready = 1;
    stepCycle();
    idle();
    #3 check("t5_drain_extended", 32'(bus.halted), 32'd0);
    stepCycle();
    #3 check("t5_halted_late", 32'(bus.halted), 32'd1);
    stepCycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_uses_rt      = 1'($urandom_range(0, 1));
      bus.ex_memread      = 1'($urandom_range(0, 1));
      bus.ex_regwrite     = ($urandom_range(0, 3) != 0);
      bus.ex_regdest      = 5'($urandom_range(0, 3));
      bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
      bus.mem_req         = ($urandom_range(0, 3) == 0);
      bus.mem_ready       = (mState == "WAIT") ? ($urandom_range(0, 4) == 0)
                                               : ($urandom_range(0, 2) != 0);
      bus.halt_req        = (mState == "HALT") ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 24) == 0);
      reset               = ($urandom_range(0, 199) == 0);
      stepCycle();
    end
    reset = 0;
    idle();
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
